// File: rtl/bsg_sdr_link_chan_arb_tx.sv
// Round-robin arbiter of chan_p credit-controlled core streams onto one SDR link word stream.
// Each link word carries its channel id in the MSBs; credits return in pulses worth D each.
module bsg_sdr_link_chan_arb_tx #(
    parameter int width_p                = 32,
    parameter int chan_p                 = 4,
    parameter int lg_credits_p           = 3,
    parameter int lg_credit_decimation_p = 0,
    localparam int id_w                  = (chan_p > 1) ? $clog2(chan_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [chan_p-1:0]           chan_en_i,
    input  logic [chan_p*width_p-1:0]   core_data_i,
    input  logic [chan_p-1:0]           core_v_i,
    output logic [chan_p-1:0]           core_ready_and_o,
    output logic [id_w+width_p-1:0]     link_data_o,
    output logic                        link_v_o,
    input  logic                        link_ready_and_i,
    input  logic                        credit_v_i,
    input  logic [id_w-1:0]             credit_chan_i,
    output logic                        credit_err_o
);

    localparam int cw     = lg_credits_p + 1;
    localparam int cap_lp = 1 << lg_credits_p;
    localparam int dec_lp = 1 << lg_credit_decimation_p;

    logic [cw-1:0]           cred_q [chan_p];
    logic [cw-1:0]           cred_d [chan_p];
    logic [cw:0]             cred_sum [chan_p];
    logic [id_w-1:0]         last_q, last_d;
    logic                    link_v_q, link_v_d;
    logic [id_w+width_p-1:0] link_data_q, link_data_d;
    logic                    err_q, err_d;

    logic [chan_p-1:0]       elig;
    logic                    out_free;
    logic                    found;
    logic                    grant_v;
    int                      gnt_idx;
    logic                    credit_chan_bad;

    // Ids beyond chan_p only exist when chan_p is not a power of two (or is 1).
    if (chan_p < (1 << id_w)) begin : g_chan_chk
        assign credit_chan_bad = (int'(credit_chan_i) >= chan_p);
    end else begin : g_chan_nochk
        assign credit_chan_bad = 1'b0;
    end

    always_comb begin
        out_free = ~link_v_q | link_ready_and_i;
        for (int i = 0; i < chan_p; i++) begin
            elig[i] = core_v_i[i] & chan_en_i[i] & (cred_q[i] != '0);
        end

        found   = 1'b0;
        gnt_idx = 0;
        for (int k = 1; k <= chan_p; k++) begin
            if (!found && elig[(int'(last_q) + k) % chan_p]) begin
                found   = 1'b1;
                gnt_idx = (int'(last_q) + k) % chan_p;
            end
        end
        // Ready must stay low while reset is held even though credits look full.
        grant_v = found & out_free & reset_n_i;

        core_ready_and_o = '0;
        if (grant_v) core_ready_and_o[gnt_idx] = 1'b1;

        link_v_d    = link_v_q;
        link_data_d = link_data_q;
        last_d      = last_q;
        if (grant_v) begin
            link_v_d    = 1'b1;
            link_data_d = {id_w'(gnt_idx), core_data_i[gnt_idx*width_p +: width_p]};
            last_d      = id_w'(gnt_idx);
        end else if (link_ready_and_i) begin
            link_v_d = 1'b0;
        end

        err_d = err_q | (credit_v_i & credit_chan_bad);
        for (int i = 0; i < chan_p; i++) begin
            cred_sum[i] = (cw+1)'(cred_q[i]);
            if (credit_v_i && !credit_chan_bad && (credit_chan_i == id_w'(i)))
                cred_sum[i] = cred_sum[i] + (cw+1)'(dec_lp);
            if (grant_v && (gnt_idx == i))
                cred_sum[i] = cred_sum[i] - (cw+1)'(1);
            if (cred_sum[i] > (cw+1)'(cap_lp)) begin
                cred_d[i] = cw'(cap_lp);
                err_d     = 1'b1;
            end else begin
                cred_d[i] = cred_sum[i][cw-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < chan_p; i++) cred_q[i] <= cw'(cap_lp);
            last_q      <= id_w'(chan_p - 1);
            link_v_q    <= 1'b0;
            link_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < chan_p; i++) cred_q[i] <= cred_d[i];
            last_q      <= last_d;
            link_v_q    <= link_v_d;
            link_data_q <= link_data_d;
            err_q       <= err_d;
        end
    end

    assign link_v_o     = link_v_q;
    assign link_data_o  = link_data_q;
    assign credit_err_o = err_q;

endmodule

// File: tb/tb_bsg_sdr_link_chan_arb_tx.sv
// Directed bench for bsg_sdr_link_chan_arb_tx: a D=1 instance for most scenarios
// and a D=4 instance for decimated credit return.
module tb_bsg_sdr_link_chan_arb_tx;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;

    logic [3:0]   chan_en, core_v;
    logic [127:0] core_data;
    logic [3:0]   core_ready;
    logic [33:0]  link_data;
    logic         link_v, link_ready, credit_v, credit_err;
    logic [1:0]   credit_chan;

    logic [3:0]   chan_en_b, core_v_b;
    logic [127:0] core_data_b;
    logic [3:0]   core_ready_b;
    logic [33:0]  link_data_b;
    logic         link_v_b, link_ready_b, credit_v_b, credit_err_b;
    logic [1:0]   credit_chan_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bsg_sdr_link_chan_arb_tx #(
        .width_p(32), .chan_p(4), .lg_credits_p(3), .lg_credit_decimation_p(0)
    ) u_dut (
        .clk_i(clk), .reset_n_i(reset_n), .chan_en_i(chan_en), .core_data_i(core_data),
        .core_v_i(core_v), .core_ready_and_o(core_ready), .link_data_o(link_data),
        .link_v_o(link_v), .link_ready_and_i(link_ready), .credit_v_i(credit_v),
        .credit_chan_i(credit_chan), .credit_err_o(credit_err)
    );

    bsg_sdr_link_chan_arb_tx #(
        .width_p(32), .chan_p(4), .lg_credits_p(3), .lg_credit_decimation_p(2)
    ) u_dut_d4 (
        .clk_i(clk), .reset_n_i(reset_n), .chan_en_i(chan_en_b), .core_data_i(core_data_b),
        .core_v_i(core_v_b), .core_ready_and_o(core_ready_b), .link_data_o(link_data_b),
        .link_v_o(link_v_b), .link_ready_and_i(link_ready_b), .credit_v_i(credit_v_b),
        .credit_chan_i(credit_chan_b), .credit_err_o(credit_err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        chan_en = 4'hF; core_v = 4'h0; core_data = '0; link_ready = 1'b1;
        credit_v = 1'b0; credit_chan = 2'd0;
        chan_en_b = 4'hF; core_v_b = 4'h0; core_data_b = '0; link_ready_b = 1'b1;
        credit_v_b = 1'b0; credit_chan_b = 2'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        core_v = 4'hF;
        core_v_b = 4'hF;
        tick();
        #1;
        n_cmp++;
        if (link_v !== 1'b0) begin n_bad++; $display("FAIL reset_link_v got %b want 0", link_v); end
        n_cmp++;
        if (link_data !== 34'd0) begin n_bad++; $display("FAIL reset_link_data got %h want 0", link_data); end
        n_cmp++;
        if (core_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got %b want 0000", core_ready); end
        n_cmp++;
        if (core_ready_b !== 4'b0000) begin n_bad++; $display("FAIL reset_ready_d4 got %b want 0000", core_ready_b); end
        n_cmp++;
        if (credit_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", credit_err); end
        do_reset();
    endtask

    task automatic test_single_channel();
        do_reset();
        core_data[2*32 +: 32] = 32'hA5;
        core_data[0 +: 32] = 32'h55;
        core_v = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++;
            if (core_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready k=%0d got %b want 0100", k, core_ready); end
            tick();
            n_cmp++;
            if (link_v !== 1'b1 || link_data !== {2'd2, 32'hA5}) begin
                n_bad++; $display("FAIL single_word k=%0d got v=%b d=%h want v=1 d=%h", k, link_v, link_data, {2'd2, 32'hA5});
            end
        end
        #1;
        n_cmp++;
        if (core_ready !== 4'b0000) begin n_bad++; $display("FAIL single_empty_ready got %b want 0000", core_ready); end
        tick();
        n_cmp++;
        if (link_v !== 1'b0) begin n_bad++; $display("FAIL single_link_idle got %b want 0", link_v); end
        // ch2 is out of credit; ch0 must still be served
        core_v = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (core_ready !== 4'b0001) begin n_bad++; $display("FAIL stalled_other_ready k=%0d got %b want 0001", k, core_ready); end
            tick();
            n_cmp++;
            if (link_data !== {2'd0, 32'h55}) begin n_bad++; $display("FAIL stalled_other_word k=%0d got %h want %h", k, link_data, {2'd0, 32'h55}); end
        end
        core_v = 4'b0000;
    endtask

    task automatic test_fairness();
        int cnt [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            core_data[i*32 +: 32] = 32'h100 + i;
            cnt[i] = 0;
        end
        core_v = 4'hF;
        for (int k = 0; k < 32; k++) begin
            #1;
            n_cmp++;
            if (core_ready !== (4'b0001 << (k % 4))) begin
                n_bad++; $display("FAIL fair_ready k=%0d got %b want %b", k, core_ready, 4'b0001 << (k % 4));
            end
            tick();
            n_cmp++;
            if (link_data !== {2'(k % 4), 32'h100 + 32'(k % 4)}) begin
                n_bad++; $display("FAIL fair_word k=%0d got %h want id %0d", k, link_data, k % 4);
            end
            cnt[link_data[33:32]]++;
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (cnt[i] !== 8) begin n_bad++; $display("FAIL fair_count ch=%0d got %0d want 8", i, cnt[i]); end
        end
        #1;
        n_cmp++;
        if (core_ready !== 4'b0000) begin n_bad++; $display("FAIL fair_exhausted got %b want 0000", core_ready); end
        core_v = 4'h0;
    endtask

    task automatic test_backpressure();
        do_reset();
        core_data[0 +: 32] = 32'h11;
        core_v = 4'b0001;
        #1;
        n_cmp++;
        if (core_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_first_ready got %b want 0001", core_ready); end
        tick();
        link_ready = 1'b0;
        core_data[0 +: 32] = 32'h22;
        for (int s = 0; s < 5; s++) begin
            #1;
            n_cmp++;
            if (core_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_stall_ready s=%0d got %b want 0000", s, core_ready); end
            tick();
            n_cmp++;
            if (link_v !== 1'b1 || link_data !== {2'd0, 32'h11}) begin
                n_bad++; $display("FAIL bp_hold s=%0d got v=%b d=%h want v=1 d=%h", s, link_v, link_data, {2'd0, 32'h11});
            end
        end
        link_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            n_cmp++;
            if (core_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_resume_ready k=%0d got %b want 0001", k, core_ready); end
            tick();
            n_cmp++;
            if (link_v !== 1'b1 || link_data !== {2'd0, 32'h22}) begin
                n_bad++; $display("FAIL bp_resume_word k=%0d got v=%b d=%h want v=1 d=%h", k, link_v, link_data, {2'd0, 32'h22});
            end
        end
        #1;
        n_cmp++;
        if (core_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_credits_used got %b want 0000", core_ready); end
        core_v = 4'h0;
    endtask

    task automatic test_chan_en();
        do_reset();
        core_data[0 +: 32] = 32'h77;
        core_v = 4'b0001;
        chan_en = 4'b1110;
        #1;
        n_cmp++;
        if (core_ready !== 4'b0000) begin n_bad++; $display("FAIL en_blocked got %b want 0000", core_ready); end
        chan_en = 4'b1111;
        #1;
        n_cmp++;
        if (core_ready !== 4'b0001) begin n_bad++; $display("FAIL en_allowed got %b want 0001", core_ready); end
        tick();
        chan_en = 4'b1110;
        link_ready = 1'b0;
        tick();
        n_cmp++;
        if (link_v !== 1'b1 || link_data !== {2'd0, 32'h77}) begin
            n_bad++; $display("FAIL en_held_word got v=%b d=%h want v=1 d=%h", link_v, link_data, {2'd0, 32'h77});
        end
        link_ready = 1'b1;
        tick();
        n_cmp++;
        if (link_v !== 1'b0) begin n_bad++; $display("FAIL en_drained got %b want 0", link_v); end
        core_v = 4'h0;
        chan_en = 4'hF;
    endtask

    task automatic test_decimation();
        int got;
        do_reset();
        core_data_b[1*32 +: 32] = 32'hD1;
        core_v_b = 4'b0010;
        got = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (core_ready_b[1]) got++;
            tick();
        end
        n_cmp++;
        if (got !== 8) begin n_bad++; $display("FAIL dec_drain got %0d want 8", got); end
        credit_v_b = 1'b1;
        credit_chan_b = 2'd1;
        #1;
        n_cmp++;
        if (core_ready_b[1] !== 1'b0) begin n_bad++; $display("FAIL dec_same_cycle got %b want 0", core_ready_b[1]); end
        tick();
        credit_v_b = 1'b0;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (core_ready_b[1]) got++;
            tick();
        end
        n_cmp++;
        if (got !== 4) begin n_bad++; $display("FAIL dec_refill got %0d want 4", got); end
        n_cmp++;
        if (credit_err_b !== 1'b0) begin n_bad++; $display("FAIL dec_err got %b want 0", credit_err_b); end
        core_v_b = 4'h0;
    endtask

    task automatic test_overflow();
        int got;
        do_reset();
        core_data[0 +: 32] = 32'h33;
        core_v = 4'b0001;
        tick();
        credit_v = 1'b1;
        credit_chan = 2'd0;
        #1;
        n_cmp++;
        if (core_ready !== 4'b0001) begin n_bad++; $display("FAIL ovf_net_grant got %b want 0001", core_ready); end
        tick();
        core_v = 4'b0000;
        credit_v = 1'b0;
        n_cmp++;
        if (credit_err !== 1'b0) begin n_bad++; $display("FAIL ovf_net_err got %b want 0", credit_err); end
        credit_v = 1'b1;
        tick();
        credit_v = 1'b0;
        n_cmp++;
        if (credit_err !== 1'b0) begin n_bad++; $display("FAIL ovf_to_full_err got %b want 0", credit_err); end
        credit_v = 1'b1;
        tick();
        credit_v = 1'b0;
        n_cmp++;
        if (credit_err !== 1'b1) begin n_bad++; $display("FAIL ovf_err got %b want 1", credit_err); end
        core_v = 4'b0001;
        got = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (core_ready[0]) got++;
            tick();
        end
        n_cmp++;
        if (got !== 8) begin n_bad++; $display("FAIL ovf_saturated got %0d want 8", got); end
        n_cmp++;
        if (credit_err !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", credit_err); end
        core_v = 4'h0;
    endtask

    task automatic test_reset_mid();
        int got;
        do_reset();
        core_data[3*32 +: 32] = 32'h99;
        core_v = 4'b1000;
        tick();
        tick();
        n_cmp++;
        if (link_v !== 1'b1) begin n_bad++; $display("FAIL mid_inflight got %b want 1", link_v); end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (link_v !== 1'b0 || link_data !== 34'd0) begin
            n_bad++; $display("FAIL mid_async got v=%b d=%h want v=0 d=0", link_v, link_data);
        end
        n_cmp++;
        if (core_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_ready got %b want 0000", core_ready); end
        tick();
        reset_n = 1'b1;
        got = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (core_ready[3]) got++;
            tick();
        end
        n_cmp++;
        if (got !== 8) begin n_bad++; $display("FAIL mid_credits got %0d want 8", got); end
        core_v = 4'h0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_channel();
        test_fairness();
        test_backpressure();
        test_chan_en();
        test_decimation();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bsg_sdr_link_chan_arb_tx.md
# bsg_sdr_link_chan_arb_tx

Multi-channel transmit front end for an SDR link. It arbitrates `chan_p` independent core streams onto one SDR link word stream, tagging each word with its channel id. It enforces per-channel credit flow control, with credits returned in decimated pulses, so that one physical link carries several virtual channels without head-of-line blocking. It sits in the core clock domain, between core producers and the core-side input of the SDR link.

## Interface
- `width_p`, 32, payload bits per channel word.
- `chan_p`, 4, number of virtual channels; must be ≥ 1.
- `lg_credits_p`, 3, log2 of the per-channel credit capacity; capacity is C = 2^lg_credits_p.
- `lg_credit_decimation_p`, 0, log2 of the credits returned per credit pulse; D = 2^lg_credit_decimation_p, with D ≤ C.
- Derived: `id_w` = `BSG_SAFE_CLOG2(chan_p)`.

Ports:
- `clk_i` in 1: sole clock.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `chan_en_i` in chan_p: per-channel enable; 0 blocks new grants for that channel.
- `core_data_i` in chan_p*width_p: channel i occupies bits [i*width_p +: width_p].
- `core_v_i` in chan_p: per-channel valid.
- `core_ready_and_o` out chan_p: per-channel ready; a transfer occurs when v & ready.
- `link_data_o` out id_w+width_p: {channel id, payload}, with the id in the MSBs.
- `link_v_o` out 1: output word valid.
- `link_ready_and_i` in 1: link accepts the word when v & ready.
- `credit_v_i` in 1: one-cycle credit-return pulse.
- `credit_chan_i` in id_w: channel that the credit pulse refers to.
- `credit_err_o` out 1: sticky error flag for credit overflow.

## Operation
- Per-channel credit counter `cred[i]`, lg_credits_p+1 bits wide; reset value is C.
- A channel is eligible when `core_v_i[i] & chan_en_i[i] & (cred[i] != 0)`.
- The output stage is a single register. `out_free = ~link_v_o | link_ready_and_i`.
- Arbitration is round-robin:
  - Pointer `last_r` resets to chan_p-1.
  - The search starts at `last_r+1`, modulo chan_p.
  - The first eligible channel g is granted only if `out_free`.
- `core_ready_and_o[g]` = 1 for the granted channel only; all other bits are 0. There is exactly one grant per cycle at most. `core_ready_and_o` depends combinationally on `core_v_i`.
- On a grant:
  - The output register loads {g, data_g} and `link_v_o` sets.
  - `last_r` becomes g.
  - `cred[g]` decrements by 1.
- If there is no grant and the link accepts the word, `link_v_o` clears.
- On a credit pulse for channel c: `cred[c]` increments by D.
  - A grant to c in the same cycle nets the two: the new value is cred+D-1.
- Overflow: if the net result exceeds C, `cred[c]` saturates at C and `credit_err_o` sets. The flag clears only on reset.
- A `credit_chan_i` value ≥ chan_p is ignored and sets `credit_err_o`.
- Deasserting `chan_en_i` does not cancel the word already held in the output register.
- When chan_p = 1, the id field is 1 bit and always reads 0.

## Timing
- Values while `reset_n_i` is low:
  - `link_v_o` = 0 and `link_data_o` = 0.
  - `core_ready_and_o` = 0 and `credit_err_o` = 0.
  - All credits equal C and `last_r` = chan_p-1.
- Reset assertion takes effect immediately. An in-flight word is dropped; its credit is not restored.
- Latency: a grant in cycle t produces `link_v_o` = 1 with that word in cycle t+1.
- Throughput: 1 word per cycle while the link stays ready and some channel is eligible.
- Backpressure: while `link_v_o & ~link_ready_and_i`, the output register and `link_data_o` hold stable and no grants are issued.
- A credit pulse in cycle t makes the channel eligible in cycle t+1 at the earliest.
- A channel with cred = 0 stalls; other channels continue to be served.

## Test plan
- Reset, then a single channel:
  - Stimulus: chan_p=4, C=8. Hold ch2 valid with data 0xA5 and the link always ready.
  - Required: 8 words {2, 0xA5} appear on cycles 1..8, then `core_ready_and_o[2]` = 0 and cred[2] = 0.
- Fairness:
  - Stimulus: all 4 channels valid, link ready.
  - Required: grant order is 0,1,2,3,0,1,…; each channel gets 8 words in 32 cycles.
- Backpressure:
  - Stimulus: hold `link_ready_and_i` = 0 for 5 cycles after the first word.
  - Required: `link_data_o` is unchanged and no credits are consumed during the stall; transfers resume at 1 per cycle.
- Decimated credit return:
  - Stimulus: D=4. Drain ch1 to cred=0, then pulse credit with chan 1.
  - Required: exactly 4 more ch1 words are accepted.
- Simultaneous events and overflow:
  - Stimulus: grant to ch0 and credit pulse for ch0 in the same cycle, with cred[0]=7 and D=1.
  - Required: cred[0] = 7 and no error.
  - Stimulus: a further credit pulse for ch0 at cred=8.
  - Required: cred[0] stays 8 and `credit_err_o` = 1 (sticky).
- Reset mid-transfer:
  - Stimulus: assert `reset_n_i` low while `link_v_o` = 1.
  - Required: `link_v_o` goes to 0 immediately and credits return to 8 after release.
